// File: rtl/periph_timer_ctrl.sv
// Memory-mapped timer / LED / 7-segment / switch peripheral on the data bus.
// Define PERIPH_SYSTICK_EN to add a free-running 32-bit SYSTICK counter at offset 0x18.
module periph_timer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       ReadData,
  input  logic [7:0]        switch,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irq
);

  typedef enum logic [2:0] {
    OFF_TH      = 3'd0,
    OFF_TL      = 3'd1,
    OFF_TCON    = 3'd2,
    OFF_LED     = 3'd3,
    OFF_SWITCH  = 3'd4,
    OFF_DIGI    = 3'd5,
    OFF_SYSTICK = 3'd6,
    OFF_RSVD    = 3'd7
  } reg_off_e;

  logic [31:0] th, tl;
  logic [2:0]  tcon;          // [0] EN, [1] IE, [2] STATUS
  logic [7:0]  sw_meta, sw_sync;
  logic [31:0] systick_val;

  reg_off_e off;
  logic     in_window, wr_sel;
  logic     wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
  logic     tl_max, overflow;

  assign off       = reg_off_e'(Address[4:2]);
  assign in_window = (Address[31:5] == BASE_ADDR[31:5]);
  assign wr_sel    = MemWrite && in_window;
  assign wr_th     = wr_sel && (off == OFF_TH);
  assign wr_tl     = wr_sel && (off == OFF_TL);
  assign wr_tcon   = wr_sel && (off == OFF_TCON);
  assign wr_led    = wr_sel && (off == OFF_LED);
  assign wr_digi   = wr_sel && (off == OFF_DIGI);

  // A software TL write in the overflow cycle cancels the whole overflow event,
  // including the STATUS set; a TCON write simply overrides STATUS.
  assign tl_max   = (tl == 32'hFFFF_FFFF);
  assign overflow = tcon[0] && tl_max && !wr_tl;

  assign irq = tcon[1] & tcon[2];

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the async reset clears everything without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr_th) th <= WriteData;

      if (wr_tl)         tl <= WriteData;
      else if (tcon[0])  tl <= tl_max ? th : tl + 32'd1;

      if (wr_tcon)                  tcon    <= WriteData[2:0];
      else if (overflow && tcon[1]) tcon[2] <= 1'b1;

      if (wr_led)  led  <= WriteData[LED_W-1:0];
      if (wr_digi) digi <= WriteData[DIGI_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick <= '0;
    else        systick <= systick + 32'd1;
  end

  assign systick_val = systick;
`else
  assign systick_val = '0;
`endif

  // NOTE: ReadData gets its default first so no path through the case infers a latch.
  always_comb begin
    ReadData = '0;
    if (MemRead && in_window) begin
      case (off)
        OFF_TH:      ReadData = th;
        OFF_TL:      ReadData = tl;
        OFF_TCON:    ReadData = {29'd0, tcon};
        OFF_LED:     ReadData = 32'(led);
        OFF_SWITCH:  ReadData = {24'd0, sw_sync};
        OFF_DIGI:    ReadData = 32'(digi);
        OFF_SYSTICK: ReadData = systick_val;
        default:     ReadData = '0;
      endcase
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[1:0];

endmodule

// File: tb/tb_periph_timer_ctrl.sv
// Scoreboard bench for periph_timer_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a read or port observation is presented.
module tb_periph_timer_ctrl;

  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam logic [31:0] A_TH     = BASE + 32'h00;
  localparam logic [31:0] A_TL     = BASE + 32'h04;
  localparam logic [31:0] A_TCON   = BASE + 32'h08;
  localparam logic [31:0] A_LED    = BASE + 32'h0C;
  localparam logic [31:0] A_SWITCH = BASE + 32'h10;
  localparam logic [31:0] A_DIGI   = BASE + 32'h14;
  localparam logic [31:0] A_TICK   = BASE + 32'h18;
  localparam logic [31:0] A_RSVD   = BASE + 32'h1C;
  localparam logic [31:0] MAXV     = 32'hFFFF_FFFF;

  logic        clk, reset;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemRead, MemWrite;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;
  logic        obs;

  typedef enum int {K_READ, K_LED, K_DIGI} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] tb_tick;

  periph_timer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .switch    (switch),
    .led       (led),
    .digi      (digi),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference cycle count since reset release, for the optional SYSTICK.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_tick <= '0;
    else        tb_tick <= tb_tick + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (MemRead || obs) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expected: output presented with empty scoreboard (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        case (e.kind)
          K_READ: begin
            check(e.name, ReadData, e.data);
            check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
          end
          K_LED:  check(e.name, {24'd0, led}, e.data);
          K_DIGI: check(e.name, {20'd0, digi}, e.data);
          default: ;
        endcase
      end
    end
  end

  task automatic drive(input logic wr, input logic rd_en, input logic [31:0] addr,
                       input logic [31:0] data);
    @(posedge clk);
    #1;
    MemWrite  = wr;
    MemRead   = rd_en;
    Address   = addr;
    WriteData = data;
    obs       = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b0, addr, data);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic eirq,
                    input string name);
    exp_t e;
    drive(1'b0, 1'b1, addr, 32'd0);
    e.name = name; e.kind = K_READ; e.data = exp; e.irq = eirq;
    sb.push_back(e);
  endtask

  task automatic look(input kind_e kind, input logic [31:0] exp, input string name);
    exp_t e;
    idle();
    obs = 1'b1;
    e.name = name; e.kind = kind; e.data = exp; e.irq = 1'b0;
    sb.push_back(e);
  endtask

  task automatic rd_tick(input string name);
    exp_t e;
    drive(1'b0, 1'b1, A_TICK, 32'd0);
    e.name = name; e.kind = K_READ; e.irq = irq;
`ifdef PERIPH_SYSTICK_EN
    e.data = tb_tick;
`else
    e.data = 32'd0;
`endif
    e.irq = 1'b0;
    sb.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; obs = 1'b0;
    Address = '0; WriteData = '0; switch = 8'h00;

    // Reset held: a write is ignored, everything reads zero.
    wr(A_TH, 32'd5);
    rd(A_TH,   32'd0, 1'b0, "rst_th");
    rd(A_TL,   32'd0, 1'b0, "rst_tl");
    rd(A_TCON, 32'd0, 1'b0, "rst_tcon");
    rd(A_DIGI, 32'd0, 1'b0, "rst_digi");
    look(K_LED, 32'd0, "rst_led_port");
    idle(); reset = 1'b1;
    rd(A_TCON, 32'd0, 1'b0, "post_rst_tcon");
    rd(A_TH,   32'd0, 1'b0, "post_rst_th");

    // Overflow with reload and interrupt, then acknowledge.
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TCON, 32'd3,          1'b0, "ovf_tcon_armed");
    rd(A_TL,   32'hFFFF_FFFF,  1'b0, "ovf_tl_max");
    rd(A_TL,   32'hFFFF_FFFD,  1'b1, "ovf_tl_reload");
    rd(A_TCON, 32'd7,          1'b1, "ovf_tcon_status");
    wr(A_TCON, 32'hFFF9 & 32'd7);
    rd(A_TCON, 32'd1,          1'b0, "ack_tcon");
    rd(A_TL,   32'hFFFF_FFFE,  1'b0, "ack_tl_counting");

    // IE off: reload happens, STATUS stays clear.
    wr(A_TCON, 32'd0);
    wr(A_TH, 32'h10);
    wr(A_TL, MAXV);
    wr(A_TCON, 32'd1);
    rd(A_TCON, 32'd1,  1'b0, "ieoff_tcon_before");
    rd(A_TL,   32'h10, 1'b0, "ieoff_tl_reload");
    rd(A_TCON, 32'd1,  1'b0, "ieoff_tcon_after");

    // TL write in the overflow cycle wins: no reload, no STATUS.
    wr(A_TCON, 32'd0);
    wr(A_TL, MAXV);
    wr(A_TCON, 32'd3);
    wr(A_TL, 32'h1234);
    rd(A_TCON, 32'd3,      1'b0, "coll_tl_tcon");
    rd(A_TL,   32'h1235,   1'b0, "coll_tl_value");

    // TCON write in the overflow cycle wins: STATUS set is lost, reload still happens.
    wr(A_TCON, 32'd0);
    wr(A_TL, MAXV);
    wr(A_TCON, 32'd3);
    wr(A_TCON, 32'd3);
    rd(A_TCON, 32'd3,  1'b0, "coll_tcon_tcon");
    rd(A_TL,   32'h11, 1'b0, "coll_tcon_tl");

    // TH write in the overflow cycle: reload uses the old TH.
    wr(A_TCON, 32'd0);
    wr(A_TL, MAXV);
    wr(A_TCON, 32'd1);
    wr(A_TH, 32'h20);
    rd(A_TL, 32'h10, 1'b0, "coll_th_old_reload");
    rd(A_TH, 32'h20, 1'b0, "coll_th_new");

    // TH all-ones: overflow every cycle.
    wr(A_TCON, 32'd0);
    wr(A_TH, MAXV);
    wr(A_TL, MAXV);
    wr(A_TCON, 32'd1);
    rd(A_TL, MAXV, 1'b0, "th_max_tl_a");
    rd(A_TL, MAXV, 1'b0, "th_max_tl_b");

    // LED / DIGI / SWITCH / decode.
    wr(A_TCON, 32'd0);
    wr(A_LED, 32'h155);
    look(K_LED, 32'h55, "led_port");
    wr(A_DIGI, 32'h0140);
    look(K_DIGI, 32'h140, "digi_port");
    rd(A_LED,  32'h55,  1'b0, "led_read");
    rd(A_DIGI, 32'h140, 1'b0, "digi_read");
    wr(BASE + 32'h2C, 32'hFF);
    rd(A_LED,  32'h55,  1'b0, "oow_write_ignored");
    rd(A_SWITCH, 32'h00, 1'b0, "sw_lag0");
    switch = 8'hA5;
    rd(A_SWITCH, 32'h00, 1'b0, "sw_lag1");
    rd(A_SWITCH, 32'hA5, 1'b0, "sw_sync");
    rd(A_RSVD,        32'd0, 1'b0, "reserved_read");
    rd(BASE + 32'h20, 32'd0, 1'b0, "oow_read");

    // SYSTICK: write ignored, two reads ten cycles apart.
    wr(A_TICK, 32'hDEAD_BEEF);
    rd_tick("systick_n");
    repeat (9) idle();
    rd_tick("systick_n10");

    // Asynchronous reset mid-count with irq pending.
    wr(A_TH, 32'h10);
    wr(A_TL, MAXV);
    wr(A_TCON, 32'd3);
    rd(A_TCON, 32'd3, 1'b0, "pre_rst_tcon");
    rd(A_TCON, 32'd7, 1'b1, "pre_rst_irq");
    rd(A_TL,   32'd0, 1'b0, "async_rst_tl");
    reset = 1'b0;
    rd(A_TH,   32'd0, 1'b0, "async_rst_th");
    idle(); reset = 1'b1;
    rd(A_TCON, 32'd0, 1'b0, "async_rst_tcon");
    rd_tick("systick_after_rst");

    idle();
    for (int i = 0; i < 4 && sb.size() != 0; i++) idle();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never observed (expected 0x%08h)", e.name, e.data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
